lcd_value_formatter: RTL and testbench
======================================

// Module: lcd_value_formatter
// PURPOSE
//  Upstream feeder for the LCD driver (top_module_lcd). Takes 8-bit unsigned results from KPN processes,
//  converts each to 3 decimal ASCII digits, and streams characters and cursor commands to the driver.
//  Packs fields of width 4 (3 digits + separator) across a 2-line display and wraps line 1 -> 2 -> 1.
// PARAMETERS
//  COLS       16     display columns; fields per line FPL = COLS/4 (COLS multiple of 4, >=4)
//  SEP_CHAR   8'h20  separator emitted after each 3-digit field
//  LINE1_CMD  8'h80  set-DDRAM command for line 1, column 0
//  LINE2_CMD  8'hC0  set-DDRAM command for line 2, column 0
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  in_value   in   8  unsigned value to display
//  in_valid   in   1  in_value is valid
//  in_ready   out  1  formatter accepts in_value this cycle (in_valid & in_ready = accept)
//  out_data   out  8  char (ASCII) or LCD command byte to the driver
//  out_rs     out  1  1 = character data, 0 = command (maps to driver rs)
//  out_valid  out  1  out_data/out_rs valid
//  out_ready  in   1  driver consumes byte (out_valid & out_ready = transfer)
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, out_data=8'h00, out_rs=0, in_ready=1; field count=0, line=1, need_cmd=1.
//  in_ready = (state==IDLE), driven from registered state only; no combinational in->out path.
//  FSM: IDLE -> CONV_H -> CONV_T -> [EMIT_CMD] -> EMIT_H -> EMIT_T -> EMIT_U -> EMIT_SEP -> IDLE.
//  IDLE: on accept, latch in_value into rem, clear h/t digit counters, go CONV_H.
//  CONV_H: one cycle per step; if rem>=100 then rem-=100, h+=1, stay; else go CONV_T.
//  CONV_T: same with 10; when rem<10, units=rem; go EMIT_CMD if need_cmd else EMIT_H.
//  Conversion cycles = h+1 + t+1 (2..13, e.g. 255 -> 2+1+5+1 = 9); out_valid rises the next cycle.
//  EMIT_*: out_valid=1; out_data/out_rs stable while out_valid & !out_ready; advance on transfer only.
//   EMIT_CMD: out_rs=0, out_data = LINE1_CMD if line==1 else LINE2_CMD; clears need_cmd.
//   EMIT_H/T/U: out_rs=1, out_data = 8'h30 + digit.  EMIT_SEP: out_rs=1, out_data=SEP_CHAR.
//  On SEP transfer: field count += 1; if count == FPL then count=0, line toggles, need_cmd=1.
//  Back-to-back: SEP transfer returns to IDLE; in_ready high the following cycle (no overlap).
//  Reset mid-operation: all state cleared immediately; partial field abandoned; next value starts with LINE1_CMD.
//  Value 0 -> "000 "; 255 -> "255 ". Digits never exceed 2/9/9; rem is 8-bit, no overflow.
// CONFIGURATION
//  LCD_LEADING_ZERO_BLANK_EN defined: leading zero digits emitted as 8'h20 (0 -> "  0 ", 7 -> "  7 ",
//   40 -> " 40 ", 105 -> "105 "). Units digit always printed. Field width unchanged (4).
//  Not defined: all three digits printed as ASCII ('0' included). Timing and FSM identical in both cases.
// STRUCTURE
//  Package lcd_fmt_pkg: FSM state encoding, ASCII_ZERO=8'h30, ASCII_SPACE=8'h20, FIELD_W=4,
//   default LINE1_CMD/LINE2_CMD constants (shared with the LCD driver).
//  Sub-module lcd_bin2dec_seq: repeated-subtraction converter (start, value[7:0] -> done, h,t,u[3:0]);
//   the formatter FSM waits on done. Output register and handshake stay in lcd_value_formatter.
// TESTING
//  1 Reset, out_ready=1, send 8'd123 -> 80(rs0), '1','2','3',' ' (31,32,33,20 rs1); first out_valid 6 cycles after accept.
//  2 Send 0 and 255 back-to-back -> "000 " then "255 "; with LCD_LEADING_ZERO_BLANK_EN -> "  0 " then "255 ".
//  3 Send FPL+1 = 5 values (COLS=16) -> LINE1_CMD before 1st, LINE2_CMD before 5th; 9 more -> LINE1_CMD before 9th.
//  4 Hold out_ready=0 for 20 cycles mid-field -> out_data/out_rs/out_valid stable; in_ready stays 0; no byte lost.
//  5 in_valid held high during EMIT -> no accept until IDLE; exactly one value consumed per field.
//  6 Assert rst_n=0 asynchronously during EMIT_T -> out_valid drops without clk; next value emits 80 then digits.

Source files
------------

// File: rtl/lcd_fmt_pkg.sv
// Shared types and constants for the LCD value formatter and the LCD driver.
// Optional build macro: LCD_LEADING_ZERO_BLANK_EN (see lcd_value_formatter).
package lcd_fmt_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned FIELD_W = 4;

    localparam logic [DATA_W-1:0] ASCII_ZERO    = 8'h30;
    localparam logic [DATA_W-1:0] ASCII_SPACE   = 8'h20;
    localparam logic [DATA_W-1:0] LINE1_CMD_DEF = 8'h80;
    localparam logic [DATA_W-1:0] LINE2_CMD_DEF = 8'hC0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_H,
        S_CONV_T,
        S_EMIT_CMD,
        S_EMIT_H,
        S_EMIT_T,
        S_EMIT_U,
        S_EMIT_SEP
    } fmt_state_t;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_H,
        CV_T
    } conv_phase_t;

    // One byte towards the LCD driver: rs=1 character, rs=0 command
    typedef struct packed {
        logic              rs;
        logic [DATA_W-1:0] data;
    } lcd_byte_t;

    function automatic logic [DATA_W-1:0] digit_char(input logic [DIGIT_W-1:0] d);
        return ASCII_ZERO + DATA_W'(d);
    endfunction

endpackage

// File: rtl/lcd_bin2dec_seq.sv
// Sequential binary-to-decimal converter: subtracts 100s, then 10s, one step per cycle.
// h_last_c / done_c flag the cycle in which each phase finishes.
module lcd_bin2dec_seq
    import lcd_fmt_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  value,
    output logic               h_last_c,
    output logic               done_c,
    output logic [DIGIT_W-1:0] h,
    output logic [DIGIT_W-1:0] t,
    output logic [DIGIT_W-1:0] u
);

    conv_phase_t        phase, phase_d;
    logic [DATA_W-1:0]  rem, rem_d;
    logic [DIGIT_W-1:0] h_d, t_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= CV_IDLE;
            rem   <= '0;
            h     <= '0;
            t     <= '0;
        end else begin
            phase <= phase_d;
            rem   <= rem_d;
            h     <= h_d;
            t     <= t_d;
        end
    end

    always_comb begin
        phase_d  = phase;
        rem_d    = rem;
        h_d      = h;
        t_d      = t;
        h_last_c = 1'b0;
        done_c   = 1'b0;
        case (phase)
            CV_IDLE: begin
                if (start) begin
                    phase_d = CV_H;
                    rem_d   = value;
                    h_d     = '0;
                    t_d     = '0;
                end
            end
            CV_H: begin
                if (rem >= DATA_W'(100)) begin
                    rem_d = rem - DATA_W'(100);
                    h_d   = h + DIGIT_W'(1);
                end else begin
                    h_last_c = 1'b1;
                    phase_d  = CV_T;
                end
            end
            CV_T: begin
                if (rem >= DATA_W'(10)) begin
                    rem_d = rem - DATA_W'(10);
                    t_d   = t + DIGIT_W'(1);
                end else begin
                    done_c  = 1'b1;
                    phase_d = CV_IDLE;
                end
            end
            default: phase_d = CV_IDLE;
        endcase
    end

    // Remainder below 10 after the tens phase is the units digit
    assign u = rem[DIGIT_W-1:0];

endmodule

// File: rtl/lcd_value_formatter.sv
// Formats 8-bit values as 4-character decimal fields and streams them to the LCD driver.
// Define LCD_LEADING_ZERO_BLANK_EN to print leading zero digits as spaces.
module lcd_value_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int unsigned       COLS      = 16,
    parameter logic [DATA_W-1:0] SEP_CHAR  = ASCII_SPACE,
    parameter logic [DATA_W-1:0] LINE1_CMD = LINE1_CMD_DEF,
    parameter logic [DATA_W-1:0] LINE2_CMD = LINE2_CMD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_rs,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned FPL   = COLS / FIELD_W;
    localparam int unsigned CNT_W = $clog2(FPL + 1);

    fmt_state_t         state, state_d;
    lcd_byte_t          obyte, obyte_d;
    logic               ovalid_d;
    logic               ready_d;
    logic               need_cmd, need_cmd_d;
    logic               line2, line2_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic               conv_start_c, h_last_c, done_c, xfer_c;
    logic [DIGIT_W-1:0] h, t, u;
    logic [DATA_W-1:0]  h_char, t_char;

    lcd_bin2dec_seq u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (conv_start_c),
        .value    (in_value),
        .h_last_c (h_last_c),
        .done_c   (done_c),
        .h        (h),
        .t        (t),
        .u        (u)
    );

`ifdef LCD_LEADING_ZERO_BLANK_EN
    assign h_char = (h == '0) ? ASCII_SPACE : digit_char(h);
    assign t_char = ((h == '0) && (t == '0)) ? ASCII_SPACE : digit_char(t);
`else
    assign h_char = digit_char(h);
    assign t_char = digit_char(t);
`endif

    assign xfer_c  = out_valid & out_ready;
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            obyte     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            need_cmd  <= 1'b1;
            line2     <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            obyte     <= obyte_d;
            out_valid <= ovalid_d;
            in_ready  <= ready_d;
            need_cmd  <= need_cmd_d;
            line2     <= line2_d;
            cnt       <= cnt_d;
        end
    end

    // Next state plus the registered output byte for the state being entered
    always_comb begin
        state_d      = state;
        obyte_d      = obyte;
        need_cmd_d   = need_cmd;
        line2_d      = line2;
        cnt_d        = cnt;
        conv_start_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    conv_start_c = 1'b1;
                    state_d      = S_CONV_H;
                end
            end
            S_CONV_H:   if (h_last_c) state_d = S_CONV_T;
            S_CONV_T:   if (done_c) state_d = need_cmd ? S_EMIT_CMD : S_EMIT_H;
            S_EMIT_CMD: begin
                if (xfer_c) begin
                    need_cmd_d = 1'b0;
                    state_d    = S_EMIT_H;
                end
            end
            S_EMIT_H:   if (xfer_c) state_d = S_EMIT_T;
            S_EMIT_T:   if (xfer_c) state_d = S_EMIT_U;
            S_EMIT_U:   if (xfer_c) state_d = S_EMIT_SEP;
            S_EMIT_SEP: begin
                if (xfer_c) begin
                    state_d = S_IDLE;
                    if (cnt_inc == CNT_W'(FPL)) begin
                        cnt_d      = '0;
                        line2_d    = ~line2;
                        need_cmd_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_EMIT_CMD: begin
                obyte_d.rs   = 1'b0;
                obyte_d.data = line2 ? LINE2_CMD : LINE1_CMD;
            end
            S_EMIT_H: begin
                obyte_d.rs   = 1'b1;
                obyte_d.data = h_char;
            end
            S_EMIT_T: begin
                obyte_d.rs   = 1'b1;
                obyte_d.data = t_char;
            end
            S_EMIT_U: begin
                obyte_d.rs   = 1'b1;
                obyte_d.data = digit_char(u);
            end
            S_EMIT_SEP: begin
                obyte_d.rs   = 1'b1;
                obyte_d.data = SEP_CHAR;
            end
            default: obyte_d = obyte;
        endcase

        ovalid_d = (state_d inside {S_EMIT_CMD, S_EMIT_H, S_EMIT_T, S_EMIT_U, S_EMIT_SEP});
        ready_d  = (state_d == S_IDLE);
    end

    assign out_data = obyte.data;
    assign out_rs   = obyte.rs;

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Scoreboard bench for lcd_value_formatter: random values and random back-pressure
// checked against a decimal/line-wrap reference model.
module tb_lcd_value_formatter;

    localparam int unsigned FPL = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_value;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_rs;
    logic       out_valid;
    logic       out_ready;

    lcd_value_formatter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_rs    (out_rs),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int accept_cyc = 0;
    int lat_exp = 0;
    bit lat_armed = 0;
    bit prev_stall = 0;
    logic [8:0] prev_byte = '0;

    bit m_line2;
    int m_cnt;
    bit m_need;

    always @(posedge clk) cyc <= cyc + 1;

    // Back-pressure generator: 0 always ready, 1 random, 2 held off
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] mk(input bit rs, input logic [7:0] d);
        return {rs, d};
    endfunction

    task automatic model_reset();
        m_line2 = 0;
        m_cnt   = 0;
        m_need  = 1;
    endtask

    task automatic model_push(input int v);
        int hd;
        int td;
        int ud;
        bit bh;
        bit bt;
        hd = v / 100;
        td = (v / 10) % 10;
        ud = v % 10;
        bh = 0;
        bt = 0;
`ifdef LCD_LEADING_ZERO_BLANK_EN
        bh = (v < 100);
        bt = (v < 10);
`endif
        if (m_need) begin
            exp_q.push_back(mk(1'b0, m_line2 ? 8'hC0 : 8'h80));
            m_need = 0;
        end
        exp_q.push_back(mk(1'b1, bh ? 8'h20 : 8'(48 + hd)));
        exp_q.push_back(mk(1'b1, bt ? 8'h20 : 8'(48 + td)));
        exp_q.push_back(mk(1'b1, 8'(48 + ud)));
        exp_q.push_back(mk(1'b1, 8'h20));
        m_cnt++;
        if (m_cnt == FPL) begin
            m_cnt   = 0;
            m_line2 = !m_line2;
            m_need  = 1;
        end
    endtask

    task automatic send(input int v, input bit arm);
        int waitc;
        waitc = 0;
        @(negedge clk);
        in_value = 8'(v);
        in_valid = 1'b1;
        while (!in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            model_push(v);
            accept_cyc = cyc;
            if (arm) begin
                lat_exp   = v / 100 + (v / 10) % 10 + 3;
                lat_armed = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clean_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        prev_stall = 0;
        lat_armed  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stability under stall
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_byte", 32'({out_rs, out_data}), 32'(prev_byte));
            end
            if (out_valid) begin
                chk("in_ready_while_emit", 32'(in_ready), 32'd0);
                if (lat_armed) begin
                    lat_armed = 0;
                    chk("first_valid_latency", 32'(cyc - accept_cyc), 32'(lat_exp));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got rs=%0b data=%02h expected none", out_rs, out_data);
                    end else begin
                        chk("byte", 32'({out_rs, out_data}), 32'(exp_q.pop_front()));
                    end
                end
                prev_stall = !out_ready;
                prev_byte  = {out_rs, out_data};
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        bit found;
        in_valid  = 1'b0;
        in_value  = 8'h00;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'h00);
        chk("reset_out_rs", 32'(out_rs), 32'd0);
        rst_n = 1'b1;

        // Single value with latency check
        rdy_mode = 0;
        send(123, 1);
        drain();

        // Boundary values back-to-back
        send(0, 0);
        send(255, 0);
        drain();

        // Line wrap: 5 fields, then 9 more
        clean_reset();
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)), 0);
        drain();
        for (int i = 0; i < 9; i++) send(int'($urandom_range(0, 255)), 0);
        drain();

        // Long stall mid-field
        rdy_mode = 0;
        send(200, 0);
        repeat (5) @(posedge clk);
        #2;
        rdy_mode  = 2;
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        rdy_mode = 0;
        drain();

        // in_valid kept asserted across fields under random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 255)), 0);
        drain();

        // Asynchronous reset while the tens digit is presented
        rdy_mode = 0;
        send(123, 0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (out_valid && out_rs && out_data == 8'h32) found = 1;
        end
        chk("reach_emit_t", 32'(found), 32'd1);
        rdy_mode  = 2;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_data", 32'(out_data), 32'h00);
        exp_q.delete();
        model_reset();
        prev_stall = 0;
        lat_armed  = 0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        send(7, 0);
        drain();

        // Random soak
        rdy_mode = 1;
        for (int i = 0; i < 30; i++) send(int'($urandom_range(0, 255)), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
